// File: rtl/writeback_arbiter.sv
// Writeback merge stage: two in-order ALU lanes plus a buffered long-latency stream onto two
// register-file write ports, with WAW squashing of stale buffered results and no writes to x0.
module writeback_arbiter #(
   parameter int DATA_W   = 16,
   parameter int MC_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          l0_valid,
   input  logic [4:0]                    l0_waddr,
   input  logic [DATA_W-1:0]             l0_wdata,
   input  logic                          l1_valid,
   input  logic [4:0]                    l1_waddr,
   input  logic [DATA_W-1:0]             l1_wdata,
   input  logic                          mc_valid,
   output logic                          mc_ready,
   input  logic [4:0]                    mc_waddr,
   input  logic [DATA_W-1:0]             mc_wdata,
   output logic                          reg_write_1,
   output logic [4:0]                    waddr_1,
   output logic [DATA_W-1:0]             wdata_1,
   output logic                          reg_write_2,
   output logic [4:0]                    waddr_2,
   output logic [DATA_W-1:0]             wdata_2,
   output logic [31:0]                   pending_mask,
   output logic [$clog2(MC_DEPTH):0]     mc_count
);

   localparam int PW = $clog2(MC_DEPTH);
   localparam int CW = PW + 1;

   logic [MC_DEPTH-1:0] e_live;
   logic [4:0]          e_waddr [MC_DEPTH];
   logic [DATA_W-1:0]   e_wdata [MC_DEPTH];
   logic [PW-1:0]       head, tail, h1;

   logic l0_ok, l1_ok, l0_surv, l1_surv, push, push_live;
   logic [MC_DEPTH-1:0] live_sq, pop_mask;

   logic              dp1_v, dp2_v, first_live, p1f, p2f, stop;
   logic [4:0]        dp1_a, dp2_a, first_a;
   logic [DATA_W-1:0] dp1_d, dp2_d;
   logic [1:0]        pop_n;

   // Long-latency handshake: a result transfers on a cycle where mc_valid && mc_ready;
   // mc_ready depends only on registered occupancy, never on this cycle's pops.
   assign mc_ready = (mc_count < CW'(MC_DEPTH));
   assign push     = mc_valid && mc_ready;

   assign l0_ok   = l0_valid && (l0_waddr != 5'd0);
   assign l1_ok   = l1_valid && (l1_waddr != 5'd0);
   assign l0_surv = l0_ok && !(l1_ok && (l1_waddr == l0_waddr));
   assign l1_surv = l1_ok;

   // Lanes are younger than anything in or entering the buffer, so matching results are stale.
   assign push_live = (mc_waddr != 5'd0)
                    && !(l0_surv && (mc_waddr == l0_waddr))
                    && !(l1_surv && (mc_waddr == l1_waddr));

   always_comb begin
      live_sq = '0;
      for (int i = 0; i < MC_DEPTH; i++) begin
         live_sq[i] = e_live[i]
                    && !(l0_surv && (e_waddr[i] == l0_waddr))
                    && !(l1_surv && (e_waddr[i] == l1_waddr));
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < MC_DEPTH; i++) begin
         if (e_live[i]) pending_mask[e_waddr[i]] = 1'b1;
      end
   end

   assign h1 = head + PW'(1);

   // Drain up to two head entries in order; a live entry takes the lowest lane-free port.
   always_comb begin
      dp1_v = 1'b0; dp1_a = '0; dp1_d = '0;
      dp2_v = 1'b0; dp2_a = '0; dp2_d = '0;
      pop_n = 2'd0;
      first_live = 1'b0;
      first_a = '0;
      p1f = !l0_surv;
      p2f = !l1_surv;
      stop = 1'b0;
      if (mc_count != '0) begin
         if (!live_sq[head]) begin
            pop_n = 2'd1;
         end else if (p1f) begin
            dp1_v = 1'b1; dp1_a = e_waddr[head]; dp1_d = e_wdata[head];
            p1f = 1'b0; pop_n = 2'd1; first_live = 1'b1; first_a = e_waddr[head];
         end else if (p2f) begin
            dp2_v = 1'b1; dp2_a = e_waddr[head]; dp2_d = e_wdata[head];
            p2f = 1'b0; pop_n = 2'd1; first_live = 1'b1; first_a = e_waddr[head];
         end else begin
            stop = 1'b1;
         end
      end else begin
         stop = 1'b1;
      end
      if (!stop && (mc_count > CW'(1))) begin
         if (!live_sq[h1]) begin
            pop_n = 2'd2;
         end else if (!first_live || (e_waddr[h1] != first_a)) begin
            if (p1f) begin
               dp1_v = 1'b1; dp1_a = e_waddr[h1]; dp1_d = e_wdata[h1];
               pop_n = 2'd2;
            end else if (p2f) begin
               dp2_v = 1'b1; dp2_a = e_waddr[h1]; dp2_d = e_wdata[h1];
               pop_n = 2'd2;
            end
         end
      end
   end

   always_comb begin
      pop_mask = '0;
      if (pop_n != 2'd0) pop_mask[head] = 1'b1;
      if (pop_n == 2'd2) pop_mask[h1]   = 1'b1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         head        <= '0;
         tail        <= '0;
         mc_count    <= '0;
         e_live      <= '0;
         for (int i = 0; i < MC_DEPTH; i++) begin
            e_waddr[i] <= '0;
            e_wdata[i] <= '0;
         end
         reg_write_1 <= 1'b0;
         waddr_1     <= '0;
         wdata_1     <= '0;
         reg_write_2 <= 1'b0;
         waddr_2     <= '0;
         wdata_2     <= '0;
      end else begin
         e_live <= live_sq & ~pop_mask;
         // The tail slot is never occupied, so it cannot collide with a popped entry.
         if (push) begin
            e_live[tail]  <= push_live;
            e_waddr[tail] <= mc_waddr;
            e_wdata[tail] <= mc_wdata;
            tail          <= tail + PW'(1);
         end
         head     <= head + PW'(pop_n);
         mc_count <= mc_count + CW'(push) - CW'(pop_n);

         reg_write_1 <= l0_surv || dp1_v;
         waddr_1     <= l0_surv ? l0_waddr : dp1_a;
         wdata_1     <= l0_surv ? l0_wdata : dp1_d;
         reg_write_2 <= l1_surv || dp2_v;
         waddr_2     <= l1_surv ? l1_waddr : dp2_a;
         wdata_2     <= l1_surv ? l1_wdata : dp2_d;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference model of the lane filtering, WAW squash and in-order drain rules.
module tb_writeback_arbiter;

   localparam int DW = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          l0_valid = 0, l1_valid = 0, mc_valid = 0;
   logic [4:0]    l0_waddr = 0, l1_waddr = 0, mc_waddr = 0;
   logic [DW-1:0] l0_wdata = 0, l1_wdata = 0, mc_wdata = 0;
   logic          mc_ready;
   logic          reg_write_1, reg_write_2;
   logic [4:0]    waddr_1, waddr_2;
   logic [DW-1:0] wdata_1, wdata_2;
   logic [31:0]   pending_mask;
   logic [2:0]    mc_count;

   writeback_arbiter #(.DATA_W(DW), .MC_DEPTH(DEPTH)) dut (
      .clk(clk), .arst_n(arst_n),
      .l0_valid(l0_valid), .l0_waddr(l0_waddr), .l0_wdata(l0_wdata),
      .l1_valid(l1_valid), .l1_waddr(l1_waddr), .l1_wdata(l1_wdata),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
      .reg_write_1(reg_write_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
      .reg_write_2(reg_write_2), .waddr_2(waddr_2), .wdata_2(wdata_2),
      .pending_mask(pending_mask), .mc_count(mc_count)
   );

   always #5 clk = ~clk;

   // Reference model: the buffer as an ordered list of {live, addr, data}.
   typedef struct packed {
      logic          live;
      logic [4:0]    a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t exp_q[$];

   logic          e_we1, e_we2;
   logic [4:0]    e_a1, e_a2;
   logic [DW-1:0] e_d1, e_d2;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      e_we1 = 0; e_a1 = 0; e_d1 = 0;
      e_we2 = 0; e_a2 = 0; e_d2 = 0;
   endtask

   function automatic logic [31:0] model_pending();
      logic [31:0] m = '0;
      foreach (exp_q[i]) if (exp_q[i].live) m[exp_q[i].a] = 1'b1;
      return m;
   endfunction

   task automatic compare_all();
      check("reg_write_1", reg_write_1, e_we1);
      check("waddr_1", waddr_1, e_a1);
      check("wdata_1", wdata_1, e_d1);
      check("reg_write_2", reg_write_2, e_we2);
      check("waddr_2", waddr_2, e_a2);
      check("wdata_2", wdata_2, e_d2);
      check("pending_mask", pending_mask, model_pending());
      check("mc_count", mc_count, exp_q.size());
      check("mc_ready", mc_ready, exp_q.size() < DEPTH);
      check("x0_write", (reg_write_1 && waddr_1 == 0) || (reg_write_2 && waddr_2 == 0), 0);
      check("dual_same", reg_write_1 && reg_write_2 && (waddr_1 == waddr_2), 0);
   endtask

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_step();
      bit   l0s, l1s, push, p1f, p2f, first_live;
      logic [4:0] fa;
      int   pops;
      ent_t e;
      l1s  = l1_valid && l1_waddr != 0;
      l0s  = l0_valid && l0_waddr != 0 && !(l1s && l1_waddr == l0_waddr);
      push = mc_valid && (exp_q.size() < DEPTH);
      foreach (exp_q[i])
         if ((l0s && exp_q[i].a == l0_waddr) || (l1s && exp_q[i].a == l1_waddr)) exp_q[i].live = 0;
      e_we1 = l0s; e_a1 = l0s ? l0_waddr : 0; e_d1 = l0s ? l0_wdata : 0;
      e_we2 = l1s; e_a2 = l1s ? l1_waddr : 0; e_d2 = l1s ? l1_wdata : 0;
      p1f = !l0s; p2f = !l1s; first_live = 0; fa = 0; pops = 0;
      while (pops < 2 && exp_q.size() > 0) begin
         e = exp_q[0];
         if (!e.live) begin
            void'(exp_q.pop_front());
            pops++;
            continue;
         end
         if (first_live && e.a == fa) break;
         if (p1f) begin
            e_we1 = 1; e_a1 = e.a; e_d1 = e.d; p1f = 0;
         end else if (p2f) begin
            e_we2 = 1; e_a2 = e.a; e_d2 = e.d; p2f = 0;
         end else break;
         first_live = 1; fa = e.a;
         void'(exp_q.pop_front());
         pops++;
      end
      if (push) begin
         e.live = mc_waddr != 0 && !(l0s && mc_waddr == l0_waddr) && !(l1s && mc_waddr == l1_waddr);
         e.a = mc_waddr;
         e.d = mc_wdata;
         exp_q.push_back(e);
      end
   endtask

   task automatic step(input bit v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [DW-1:0] d1,
                       input bit vm, input logic [4:0] am, input logic [DW-1:0] dm);
      @(negedge clk);
      compare_all();
      l0_valid = v0; l0_waddr = a0; l0_wdata = d0;
      l1_valid = v1; l1_waddr = a1; l1_wdata = d1;
      mc_valid = vm; mc_waddr = am; mc_wdata = dm;
      model_step();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 0;
      l0_valid = 0; l1_valid = 0; mc_valid = 0;
      model_reset();
      @(negedge clk);
      compare_all();
      arst_n = 1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // Two lanes to distinct registers, visible for exactly one cycle.
      step(1, 3, 16'h1111, 1, 4, 16'h2222, 0, 0, 0);
      settle();
      check("ex1_p1", {reg_write_1, waddr_1, wdata_1}, {1'b1, 5'd3, 16'h1111});
      check("ex1_p2", {reg_write_2, waddr_2, wdata_2}, {1'b1, 5'd4, 16'h2222});
      idle();
      settle();
      check("ex1_once", reg_write_1 | reg_write_2, 0);

      // Same destination on both lanes: only the younger lane writes.
      step(1, 5, 16'hAAAA, 1, 5, 16'hBBBB, 0, 0, 0);
      settle();
      check("ex2_p1_off", reg_write_1, 0);
      check("ex2_p2", {reg_write_2, waddr_2, wdata_2}, {1'b1, 5'd5, 16'hBBBB});

      // Long-latency result waits while both lanes are busy.
      step(1, 1, 16'h0101, 1, 2, 16'h0202, 1, 7, 16'h0707);
      settle();
      check("ex3_pend", pending_mask[7], 1);
      check("ex3_cnt", mc_count, 1);
      step(1, 1, 16'h0111, 1, 2, 16'h0222, 0, 0, 0);
      step(1, 1, 16'h0121, 1, 2, 16'h0232, 0, 0, 0);
      idle();
      settle();
      check("ex3_drain", {reg_write_1, waddr_1, wdata_1}, {1'b1, 5'd7, 16'h0707});

      // Buffered r9 is squashed by a younger lane write.
      step(1, 1, 16'h0001, 1, 2, 16'h0002, 1, 9, 16'h9999);
      step(0, 0, 0, 1, 9, 16'h0009, 0, 0, 0);
      settle();
      check("ex4_pend", pending_mask[9], 0);
      check("ex4_p2", {reg_write_2, waddr_2, wdata_2}, {1'b1, 5'd9, 16'h0009});
      check("ex4_p1_off", reg_write_1, 0);
      for (int i = 0; i < 3; i++) idle();

      // Fill the buffer while lanes are busy, then drain two per cycle.
      for (int i = 0; i < 6; i++) step(1, 1, 16'h1000, 1, 2, 16'h2000, 1, 5'(10 + i), 16'(16'h0A00 + i));
      settle();
      check("ex5_full", mc_ready, 0);
      for (int i = 0; i < 4; i++) idle();
      settle();
      check("ex5_ready", mc_ready, 1);

      // Address zero on every source never writes.
      step(1, 0, 16'hDEAD, 1, 0, 16'hBEEF, 1, 0, 16'hCAFE);
      settle();
      check("ex6_none", reg_write_1 | reg_write_2, 0);
      idle(); idle();

      // Reset with a full buffer clears everything.
      for (int i = 0; i < 4; i++) step(1, 1, 16'h1000, 1, 2, 16'h2000, 1, 5'(20 + i), 16'(i));
      do_reset();

      // Randomized traffic with alternating busy/quiet phases and narrow address space.
      for (int c = 0; c < 3000; c++) begin
         int pl;
         pl = ((c / 64) % 2 == 0) ? 85 : 25;
         if (c == 1500) do_reset();
         step($urandom_range(0, 99) < pl, 5'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(0, 99) < pl, 5'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(0, 99) < 50,
              5'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)),
              16'($urandom));
      end
      idle(); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
